// File: rtl/pattern_serializer.sv
// rtl/pattern_serializer.sv - captures one word per valid/ready handshake and sends it as a serial frame
module pattern_serializer #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int PARITY_EN = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state, nxt_state;
    logic [DIV_W-1:0]  div_cnt, nxt_div;
    logic [BIT_W-1:0]  bit_cnt, nxt_bit;
    logic [DATA_W-1:0] shift_reg, nxt_shift;
    logic              par_bit, nxt_par;
    logic              nxt_ser;

    always_comb begin
        nxt_state = state;
        nxt_div   = div_cnt;
        nxt_bit   = bit_cnt;
        nxt_shift = shift_reg;
        nxt_par   = par_bit;
        if (state == S_IDLE) begin
            if (in_valid && in_ready) begin
                nxt_state = S_START;
                nxt_shift = in_data;
                nxt_par   = ^in_data;
                nxt_div   = '0;
                nxt_bit   = '0;
            end
        end else if (div_cnt == DIV_MAX) begin
            nxt_div = '0;
            case (state)
                S_START: begin
                    nxt_state = S_DATA;
                    nxt_bit   = '0;
                end
                S_DATA: begin
                    if (bit_cnt == BIT_MAX) begin
                        nxt_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        nxt_bit   = bit_cnt + 1'b1;
                        nxt_shift = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
                    end
                end
                S_PARITY: nxt_state = S_STOP;
                default:  nxt_state = S_IDLE;
            endcase
        end else begin
            nxt_div = div_cnt + 1'b1;
        end
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_comb begin
        nxt_ser = 1'b1;
        case (nxt_state)
            S_START:  nxt_ser = 1'b0;
            S_DATA:   nxt_ser = (MSB_FIRST != 0) ? nxt_shift[DATA_W-1] : nxt_shift[0];
            S_PARITY: nxt_ser = nxt_par;
            default:  nxt_ser = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            ser_out    <= 1'b1;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            div_cnt    <= nxt_div;
            bit_cnt    <= nxt_bit;
            shift_reg  <= nxt_shift;
            par_bit    <= nxt_par;
            ser_out    <= nxt_ser;
            in_ready   <= (nxt_state == S_IDLE);
            busy       <= (nxt_state != S_IDLE);
            frame_done <= (nxt_state == S_STOP) && (nxt_div == DIV_MAX);
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// tb/tb_pattern_serializer.sv - directed vector bench for pattern_serializer
module tb_pattern_serializer;

    logic       clk;
    logic       rstn  [3];
    logic [7:0] data  [3];
    logic       valid [3];
    logic       rdy   [3];
    logic       ser   [3];
    logic       bsy   [3];
    logic       done  [3];

    int checks;
    int errors;
    int done_cnt;

    pattern_serializer #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rstn[0]), .in_data(data[0]), .in_valid(valid[0]),
        .in_ready(rdy[0]), .ser_out(ser[0]), .busy(bsy[0]), .frame_done(done[0]));

    pattern_serializer #(.DATA_W(8), .CLK_DIV(4), .PARITY_EN(1), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rstn[1]), .in_data(data[1]), .in_valid(valid[1]),
        .in_ready(rdy[1]), .ser_out(ser[1]), .busy(bsy[1]), .frame_done(done[1]));

    pattern_serializer #(.DATA_W(8), .CLK_DIV(1), .PARITY_EN(0), .MSB_FIRST(1)) u_fast (
        .clk(clk), .rst_n(rstn[2]), .in_data(data[2]), .in_valid(valid[2]),
        .in_ready(rdy[2]), .ser_out(ser[2]), .busy(bsy[2]), .frame_done(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [7:0]  word;
        logic [10:0] exp;
        int          nbits;
        int          div;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int idx, input string name);
        chk({name, " ready"}, 32'(rdy[idx]), 32'd1);
        chk({name, " busy"},  32'(bsy[idx]), 32'd0);
        chk({name, " ser"},   32'(ser[idx]), 32'd1);
        chk({name, " done"},  32'(done[idx]), 32'd0);
    endtask

    task automatic accept(input int idx, input logic [7:0] word);
        @(negedge clk);
        data[idx]  = word;
        valid[idx] = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accept edge; k-th transmitted bit is exp[nbits-1-k].
    task automatic run_frame(input int idx, input logic [10:0] exp, input int nbits, input int div,
                             input string name, input bit hold, input logic [7:0] nxt);
        int total;
        int b;
        total = nbits * div;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            b = (c - 1) / div;
            chk($sformatf("%s c%0d ser", name, c), 32'(ser[idx]), 32'(exp[nbits-1-b]));
            chk($sformatf("%s c%0d done", name, c), 32'(done[idx]), (c == total) ? 32'd1 : 32'd0);
            chk($sformatf("%s c%0d ready", name, c), 32'(rdy[idx]), 32'd0);
            chk($sformatf("%s c%0d busy", name, c), 32'(bsy[idx]), 32'd1);
            if (done[idx]) done_cnt++;
            if (hold) data[idx] = (c == total) ? nxt : 8'($urandom);
            else      valid[idx] = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 3; i++) begin
            rstn[i]  = 1'b0;
            data[i]  = 8'h00;
            valid[i] = 1'b0;
        end

        vecs[0] = '{0, 8'h80, 11'b0_10000000_1_1, 11, 4};
        vecs[1] = '{0, 8'hA5, 11'b0_10100101_0_1, 11, 4};
        vecs[2] = '{0, 8'h01, 11'b0_00000001_1_1, 11, 4};
        vecs[3] = '{1, 8'h01, 11'b0_10000000_1_1, 11, 4};
        vecs[4] = '{1, 8'h35, 11'b0_10101100_0_1, 11, 4};
        vecs[5] = '{2, 8'hFF, {1'b0, 10'b0_11111111_1}, 10, 1};
        vecs[6] = '{2, 8'h00, {1'b0, 10'b0_00000000_1}, 10, 1};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("reset%0d", i));
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i, $sformatf("post_reset%0d", i));

        foreach (vecs[v]) begin
            accept(vecs[v].idx, vecs[v].word);
            run_frame(vecs[v].idx, vecs[v].exp, vecs[v].nbits, vecs[v].div,
                      $sformatf("vec%0d", v), 1'b0, 8'h00);
            @(negedge clk);
            check_idle(vecs[v].idx, $sformatf("vec%0d idle", v));
        end

        // Back-to-back with valid held and in_data churning while busy.
        done_cnt = 0;
        accept(0, 8'h80);
        run_frame(0, 11'b0_10000000_1_1, 11, 4, "b2b80", 1'b1, 8'h40);
        @(negedge clk);
        check_idle(0, "b2b gap1");
        @(posedge clk);
        run_frame(0, 11'b0_01000000_1_1, 11, 4, "b2b40", 1'b1, 8'h20);
        @(negedge clk);
        check_idle(0, "b2b gap2");
        @(posedge clk);
        run_frame(0, 11'b0_00100000_1_1, 11, 4, "b2b20", 1'b0, 8'h00);
        @(negedge clk);
        check_idle(0, "b2b end");
        chk("b2b done pulses", 32'(done_cnt), 32'd3);

        // Reset mid-frame on the default instance: outputs must clear asynchronously.
        accept(0, 8'h00);
        repeat (10) @(negedge clk);
        valid[0] = 1'b0;
        chk("mid busy before reset", 32'(bsy[0]), 32'd1);
        chk("mid ser before reset", 32'(ser[0]), 32'd0);
        rstn[0] = 1'b0;
        #1;
        check_idle(0, "async reset");
        @(negedge clk);
        rstn[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("after reset c%0d done", c), 32'(done[0]), 32'd0);
            chk($sformatf("after reset c%0d ser", c), 32'(ser[0]), 32'd1);
        end

        // Fast build: reset at clock 5 of an FF frame.
        accept(2, 8'hFF);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            valid[2] = 1'b0;
            chk($sformatf("fast c%0d ser", c), 32'(ser[2]), (c == 1) ? 32'd0 : 32'd1);
            chk($sformatf("fast c%0d busy", c), 32'(bsy[2]), 32'd1);
        end
        rstn[2] = 1'b0;
        #1;
        check_idle(2, "fast reset");
        @(negedge clk);
        rstn[2] = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check_idle(2, $sformatf("fast after reset c%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
